spi_cfg_sequencer: RTL and testbench
====================================

Name: spi_cfg_sequencer

Overview:
- APB master that runs the SPI-slave configuration download in hardware, replacing software-driven byte writes.
- On i_start it asserts o_CONFIG and sends 10 configuration bytes to the SPI slave: F8, RX count hi/lo; F9, TX count hi/lo; FA, oscillator frequency; FB, arthur bits.
- Each byte is sent as three APB writes into APB_interface_2: CONFIG register, TX register, CMD register.
- Sits between system control logic and the APB port of APB_interface_2.

Parameters:
- BASE_ADDR, 16'h0040, address of CONFIG register; TX = BASE_ADDR+4, CMD = BASE_ADDR+12.
- CFG_WORD, 8'h0D, CONFIG register value {2'b00, MODE00, SLAVE3, SCK4}.
- CMD_WORD, 8'h02, CMD register value that starts the SPI transfer.
- BYTE_GAP, 72, idle cycles after each CMD write (SPI byte time at SCK4).
- CFG_SETUP, 3, cycles o_CONFIG is high before the first APB transfer.
- CFG_HOLD, 3, cycles o_CONFIG stays high after the last BYTE_GAP.
- TIMEOUT, 255, maximum ACCESS cycles to wait for i_PREADY.

Ports:
- i_PCLK  in  1  clock
- i_PRESETn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; begins a sequence
- i_osc_freq  in  8  oscillator frequency byte
- i_arthur  in  8  arthur bits byte
- i_cnt_rx  in  16  external RX count value
- i_cnt_tx  in  16  external TX count value
- i_PREADY  in  1  APB ready from slave
- o_PSEL  out  1  APB select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB write; always 1 while o_PSEL=1
- o_PADDR  out  16  APB address
- o_PWDATA  out  8  APB write data
- o_CONFIG  out  1  configuration-mode pin to SPI slave
- o_busy  out  1  high from the cycle after accepted i_start until DONE/ERR
- o_done  out  1  one-cycle pulse on successful completion
- o_err  out  1  one-cycle pulse on PREADY timeout

Behaviour:
- Reset (async, i_PRESETn=0):
  - All outputs 0; o_PADDR=0, o_PWDATA=0; state IDLE; counters cleared.
  - Reset mid-sequence aborts immediately: o_CONFIG and o_PSEL drop asynchronously.
- Start:
  - i_start is accepted only in IDLE; it is ignored while o_busy=1.
  - On accept, i_osc_freq, i_arthur, i_cnt_rx and i_cnt_tx are latched into a 10-byte schedule: F8, rx[15:8], rx[7:0], F9, tx[15:8], tx[7:0], FA, osc, FB, arthur.
  - Later input changes do not affect the running sequence.
- States:
  - IDLE: on i_start go to CFG_SETUP; o_CONFIG=1.
  - CFG_SETUP: count CFG_SETUP cycles, then go to APB_SETUP with byte_idx=0, phase=0.
  - APB_SETUP: o_PSEL=1, o_PENABLE=0, o_PWRITE=1. Address/data by phase:
    - phase 0: BASE_ADDR / CFG_WORD
    - phase 1: BASE_ADDR+4 / schedule[byte_idx]
    - phase 2: BASE_ADDR+12 / CMD_WORD
    - Always exactly 1 cycle, then APB_ACCESS.
  - APB_ACCESS: o_PSEL=1, o_PENABLE=1; address and data held stable.
    - Each cycle with i_PREADY=1 completes the transfer and goes to APB_GAP.
    - If i_PREADY stays low for TIMEOUT consecutive cycles, go to ERR.
  - APB_GAP: one cycle with o_PSEL=o_PENABLE=0. Then:
    - phase<2: phase+1, go to APB_SETUP.
    - phase==2: phase=0, go to BYTE_WAIT.
  - BYTE_WAIT: count BYTE_GAP cycles, then:
    - byte_idx<9: byte_idx+1, go to APB_SETUP.
    - byte_idx==9: go to CFG_HOLD.
  - CFG_HOLD: count CFG_HOLD cycles, then go to DONE.
  - DONE: o_done=1 for 1 cycle; o_CONFIG=0, o_busy=0; return to IDLE.
  - ERR: o_err=1 for 1 cycle; o_CONFIG=0, o_PSEL=0, o_busy=0; return to IDLE. The partial download is not retried.
- o_PADDR and o_PWDATA are registered and hold their last value when o_PSEL=0.
- Zero wait states (i_PREADY tied high): each write takes 3 cycles (SETUP, ACCESS, GAP).
- Nominal total with zero wait states: CFG_SETUP + 10*(9+BYTE_GAP) + CFG_HOLD + 1 = 817 cycles, measured from the accept cycle to the o_done cycle.
- i_start arriving in the same cycle as o_done is ignored.
- A single cycle's i_start pulse in IDLE is accepted.
- Byte index wraps are not allowed; the sequence always ends after exactly 10 bytes.

Test Plan:
- Nominal run:
  - Stimulus: i_PREADY=1; osc=03, arthur=4D, rx=2710, tx=2500; pulse i_start.
  - Required: 30 APB writes. TX-register data sequence is F8,27,10,F9,25,00,FA,03,FB,4D. Every CONFIG write carries 0D, every CMD write carries 02.
  - Required: o_done 817 cycles after start; o_CONFIG high throughout and low after.
- Wait states:
  - Stimulus: i_PREADY low for 4 cycles in each ACCESS.
  - Required: PADDR/PWDATA stable during the stall; total duration grows by exactly 120 cycles; same data order.
- Timeout:
  - Stimulus: i_PREADY stuck at 0.
  - Required: o_err pulses after 255 ACCESS cycles of the first transfer; o_PSEL=0, o_CONFIG=0, o_done never asserted.
- Busy guard:
  - Stimulus: second i_start mid-sequence, with osc=01 applied on the inputs.
  - Required: ignored; the FA byte is followed by 03, not 01.
- Reset mid-operation:
  - Stimulus: i_PRESETn low during byte 5 ACCESS.
  - Required: all outputs 0 immediately; a new start after release runs a full clean 10-byte sequence.
- SPI end-to-end:
  - Stimulus: connect to APB_interface_2 and TOP; run with rx=2510, tx=2900, osc=01, arthur=81.
  - Required: slave arthur=81, osc_freq=01, and its RX/TX counters load 2510/2900.

Source files
------------

// File: rtl/spi_cfg_sequencer_if.sv
// ----------------------------------------------------------------------------
// spi_cfg_sequencer_if
//
// APB write-side bus between the configuration sequencer (master) and the
// APB port of the SPI controller (slave).
//
//   PSEL     master -> slave   select
//   PENABLE  master -> slave   access phase
//   PWRITE   master -> slave   write strobe (always 1 while PSEL=1)
//   PADDR    master -> slave   16-bit register address
//   PWDATA   master -> slave   8-bit write data
//   PREADY   slave  -> master  transfer complete
// ----------------------------------------------------------------------------
interface spi_cfg_sequencer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PADDR;
    logic [7:0]  PWDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY
    );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// spi_cfg_sequencer
//
// APB master that downloads the 10-byte SPI-slave configuration in hardware.
// Every byte goes out as three APB writes (CONFIG, TX, CMD register),
// followed by a fixed idle gap covering the SPI byte time. o_CONFIG frames
// the whole download, with a setup/hold margin on either side.
//
// Ports:
//   i_PCLK      clock
//   i_PRESETn   asynchronous active-low reset
//   i_start     single-cycle pulse, accepted only while idle
//   i_osc_freq  oscillator frequency byte   (latched on accept)
//   i_arthur    arthur bits byte            (latched on accept)
//   i_cnt_rx    RX count                    (latched on accept)
//   i_cnt_tx    TX count                    (latched on accept)
//   apb         APB master port (PSEL/PENABLE/PWRITE/PADDR/PWDATA, PREADY)
//   o_CONFIG    configuration-mode pin to the SPI slave
//   o_busy      high while a download is in progress
//   o_done      one-cycle pulse on successful completion
//   o_err       one-cycle pulse when PREADY never arrives within TIMEOUT
// ----------------------------------------------------------------------------
module spi_cfg_sequencer #(
    parameter logic [15:0] BASE_ADDR = 16'h0040,
    parameter logic [7:0]  CFG_WORD  = 8'h0D,
    parameter logic [7:0]  CMD_WORD  = 8'h02,
    parameter int unsigned BYTE_GAP  = 72,
    parameter int unsigned CFG_SETUP = 3,
    parameter int unsigned CFG_HOLD  = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                       i_PCLK,
    input  logic                       i_PRESETn,
    input  logic                       i_start,
    input  logic [7:0]                 i_osc_freq,
    input  logic [7:0]                 i_arthur,
    input  logic [15:0]                i_cnt_rx,
    input  logic [15:0]                i_cnt_tx,
    spi_cfg_sequencer_if.master        apb,
    output logic                       o_CONFIG,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);
    // One shared counter serves every timed state; size it for the longest.
    localparam int unsigned MAX_A   = (BYTE_GAP > TIMEOUT) ? BYTE_GAP : TIMEOUT;
    localparam int unsigned MAX_B   = (CFG_SETUP > CFG_HOLD) ? CFG_SETUP : CFG_HOLD;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(CFG_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CFG_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_BYTE    = 4'd9;
    localparam logic [1:0]       LAST_PHASE   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_SETUP,
        S_APB_SETUP,
        S_APB_ACCESS,
        S_APB_GAP,
        S_BYTE_WAIT,
        S_CFG_HOLD,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       phase_q, phase_d;   // 0: CONFIG, 1: TX, 2: CMD
    logic [3:0]       idx_q, idx_d;       // schedule byte being sent
    logic [15:0]      rx_q, tx_q;
    logic [7:0]       osc_q, arthur_q;
    logic [15:0]      paddr_q;
    logic [7:0]       pwdata_q;
    logic [7:0]       sched_byte;
    logic [15:0]      setup_addr;
    logic [7:0]       setup_data;
    logic             psel, penable;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CFG_SETUP;
                    phase_d = '0;
                    idx_d   = '0;
                end
            end
            S_CFG_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = S_APB_SETUP;
            end
            S_APB_SETUP: state_d = S_APB_ACCESS;
            S_APB_ACCESS: begin
                // cnt_q counts consecutive ACCESS cycles, all of them with PREADY low.
                if (apb.PREADY)                 state_d = S_APB_GAP;
                else if (cnt_q == TIMEOUT_LAST) state_d = S_ERR;
            end
            S_APB_GAP: begin
                if (phase_q != LAST_PHASE) begin
                    phase_d = phase_q + 2'd1;
                    state_d = S_APB_SETUP;
                end else begin
                    phase_d = '0;
                    state_d = S_BYTE_WAIT;
                end
            end
            S_BYTE_WAIT: begin
                if (cnt_q == GAP_LAST) begin
                    if (idx_q != LAST_BYTE) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_APB_SETUP;
                    end else begin
                        state_d = S_CFG_HOLD;
                    end
                end
            end
            S_CFG_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;   // DONE, ERR
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        psel     = 1'b0;
        penable  = 1'b0;
        o_CONFIG = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_err    = 1'b0;
        case (state_q)
            S_CFG_SETUP, S_APB_GAP, S_BYTE_WAIT, S_CFG_HOLD: begin
                o_CONFIG = 1'b1;
                o_busy   = 1'b1;
            end
            S_APB_SETUP: begin
                o_CONFIG = 1'b1;
                o_busy   = 1'b1;
                psel     = 1'b1;
            end
            S_APB_ACCESS: begin
                o_CONFIG = 1'b1;
                o_busy   = 1'b1;
                psel     = 1'b1;
                penable  = 1'b1;
            end
            S_DONE:  o_done = 1'b1;
            S_ERR:   o_err  = 1'b1;
            default: ;
        endcase
    end

    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PWRITE  = psel;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

    // ------------------------------------------------------------- datapath
    always_comb begin
        case (idx_d)
            4'd0:    sched_byte = 8'hF8;
            4'd1:    sched_byte = rx_q[15:8];
            4'd2:    sched_byte = rx_q[7:0];
            4'd3:    sched_byte = 8'hF9;
            4'd4:    sched_byte = tx_q[15:8];
            4'd5:    sched_byte = tx_q[7:0];
            4'd6:    sched_byte = 8'hFA;
            4'd7:    sched_byte = osc_q;
            4'd8:    sched_byte = 8'hFB;
            default: sched_byte = arthur_q;
        endcase
    end

    always_comb begin
        case (phase_d)
            2'd0: begin
                setup_addr = BASE_ADDR;
                setup_data = CFG_WORD;
            end
            2'd1: begin
                setup_addr = BASE_ADDR + 16'd4;
                setup_data = sched_byte;
            end
            default: begin
                setup_addr = BASE_ADDR + 16'd12;
                setup_data = CMD_WORD;
            end
        endcase
    end

    // NOTE: reset is asynchronous, so an abort drops PSEL/CONFIG without a clock.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            idx_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            osc_q    <= '0;
            arthur_q <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;

            // Every state entry restarts the count; idle does not count.
            if (state_d != state_q)     cnt_q <= '0;
            else if (state_q != S_IDLE) cnt_q <= cnt_q + CNT_W'(1);

            if (state_q == S_IDLE && i_start) begin
                rx_q     <= i_cnt_rx;
                tx_q     <= i_cnt_tx;
                osc_q    <= i_osc_freq;
                arthur_q <= i_arthur;
            end

            // Address/data are loaded once on SETUP entry and then held through
            // ACCESS and every idle cycle until the next transfer.
            if (state_d == S_APB_SETUP) begin
                paddr_q  <= setup_addr;
                pwdata_q <= setup_data;
            end
        end
    end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_cfg_sequencer
//
// Drives configuration downloads with random data and random APB wait states
// and compares the observed write stream, durations and control pins with
// values computed from the download rules (schedule list, per-write cost,
// fixed setup/gap/hold times).
// ----------------------------------------------------------------------------
module tb_spi_cfg_sequencer;
    localparam logic [15:0] BASE     = 16'h0040;
    localparam logic [7:0]  CFG      = 8'h0D;
    localparam logic [7:0]  CMD      = 8'h02;
    localparam int          N_WRITES = 30;
    // 3 setup + 10 bytes * (3 writes * 3 cycles + 72 gap) + 3 hold + 1 done
    localparam int          NOMINAL  = 3 + 10 * (9 + 72) + 3 + 1;
    // 3 setup + 1 APB setup + 255 stalled access cycles + 1 error cycle
    localparam int          ERR_AT   = 3 + 1 + 255 + 1;
    localparam int          BUDGET   = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  osc, art;
    logic [15:0] rx, tx;
    logic        o_config, o_busy, o_done, o_err;

    int n_checks = 0;
    int n_errors = 0;

    spi_cfg_sequencer_if apb ();

    spi_cfg_sequencer dut (
        .i_PCLK     (clk),
        .i_PRESETn  (rst_n),
        .i_start    (start),
        .i_osc_freq (osc),
        .i_arthur   (art),
        .i_cnt_rx   (rx),
        .i_cnt_tx   (tx),
        .apb        (apb),
        .o_CONFIG   (o_config),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_pins();
        return 32'({apb.PSEL, apb.PENABLE, apb.PWRITE, o_config, o_busy, o_done, o_err});
    endfunction

    // One complete download. Starts and ends 1 time unit after a rising edge.
    //   wait_mode >= 0 : that many PREADY-low cycles in every ACCESS
    //   wait_mode <  0 : random 0..3 low cycles per ACCESS
    //   stuck          : PREADY never rises during ACCESS
    //   poke           : second start (with osc=01) in the middle of the run
    //   abort_at >= 0  : assert reset during the ACCESS of that write index
    task automatic run_seq(input string name, input logic [15:0] s_rx, input logic [15:0] s_tx,
                           input logic [7:0] s_osc, input logic [7:0] s_art,
                           input int wait_mode, input bit stuck, input bit poke,
                           input int abort_at);
        logic [7:0]  sched [10];
        logic [23:0] exp_q [$];
        logic [23:0] got_q [$];
        logic [15:0] hold_addr;
        logic [7:0]  hold_data;
        int          k, acc, w, waits_total, done_k, err_k;
        int          stable_bad, pin_bad, pwrite_bad, late_done;
        bit          finished, aborted, err_psel, err_cfg, done_cfg;

        sched = '{8'hF8, s_rx[15:8], s_rx[7:0], 8'hF9, s_tx[15:8], s_tx[7:0],
                  8'hFA, s_osc, 8'hFB, s_art};
        foreach (sched[i]) begin
            exp_q.push_back({BASE, CFG});
            exp_q.push_back({BASE + 16'd4, sched[i]});
            exp_q.push_back({BASE + 16'd12, CMD});
        end

        k = 0; acc = 0; w = 0; waits_total = 0; done_k = -1; err_k = -1;
        stable_bad = 0; pin_bad = 0; pwrite_bad = 0; late_done = 0;
        finished = 0; aborted = 0; err_psel = 0; err_cfg = 0; done_cfg = 0;
        hold_addr = '0; hold_data = '0;

        rx = s_rx; tx = s_tx; osc = s_osc; art = s_art;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (!finished && k < BUDGET) begin
            k++;
            start = poke && (k == 100);
            if (poke && k == 100) begin
                osc = 8'h01;
                rx  = 16'($urandom);
            end
            if (apb.PSEL && apb.PWRITE !== 1'b1) pwrite_bad++;

            if (apb.PSEL && !apb.PENABLE) begin
                acc       = 0;
                w         = (wait_mode >= 0) ? wait_mode : int'($urandom_range(0, 3));
                hold_addr = apb.PADDR;
                hold_data = apb.PWDATA;
                apb.PREADY = 1'b0;
            end else if (apb.PSEL && apb.PENABLE) begin
                acc++;
                if (apb.PADDR !== hold_addr || apb.PWDATA !== hold_data) stable_bad++;
                if (abort_at >= 0 && got_q.size() == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check({name, ":reset_ctrl"}, ctrl_pins(), 32'd0);
                    check({name, ":reset_addr"}, 32'(apb.PADDR), 32'd0);
                    check({name, ":reset_data"}, 32'(apb.PWDATA), 32'd0);
                    aborted  = 1;
                    finished = 1;
                end else if (!stuck && acc > w) begin
                    apb.PREADY = 1'b1;
                    got_q.push_back({apb.PADDR, apb.PWDATA});
                    waits_total += w;
                end else begin
                    apb.PREADY = 1'b0;
                end
            end else begin
                apb.PREADY = 1'($urandom_range(0, 1));   // ignored outside ACCESS
            end

            if (!aborted) begin
                if (!o_done && !o_err && (o_config !== 1'b1 || o_busy !== 1'b1)) pin_bad++;
                if (o_done) begin
                    finished = 1;
                    done_k   = k;
                    done_cfg = o_config;
                    start    = 1'b1;    // must be ignored in the DONE cycle
                end
                if (o_err) begin
                    finished = 1;
                    err_k    = k;
                    err_psel = apb.PSEL;
                    err_cfg  = o_config;
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
            end
        end

        if (!finished) begin
            check({name, ":finished_in_budget"}, 32'd0, 32'd1);
            start = 1'b0;
            return;
        end

        check({name, ":addr_data_stable"}, 32'(stable_bad), 32'd0);
        check({name, ":pwrite_high"}, 32'(pwrite_bad), 32'd0);

        if (aborted) begin
            for (int i = 0; i < got_q.size(); i++)
                check($sformatf("%s:pre_abort_write%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
            @(posedge clk); @(posedge clk); #1;
            check({name, ":reset_held"}, ctrl_pins(), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            apb.PREADY = 1'b0;
            check({name, ":idle_after_release"}, ctrl_pins(), 32'd0);
            return;
        end

        check({name, ":config_busy_high"}, 32'(pin_bad), 32'd0);

        if (stuck) begin
            check({name, ":err_cycle"}, 32'(err_k), 32'(ERR_AT));
            check({name, ":err_psel"}, 32'(err_psel), 32'd0);
            check({name, ":err_config"}, 32'(err_cfg), 32'd0);
            check({name, ":err_no_writes"}, 32'(got_q.size()), 32'd0);
            @(posedge clk); #1;
            check({name, ":err_one_cycle"}, ctrl_pins(), 32'd0);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                if (o_done) late_done++;
            end
            check({name, ":no_done_after_err"}, 32'(late_done), 32'd0);
        end else begin
            check({name, ":done_cycle"}, 32'(done_k), 32'(NOMINAL + waits_total));
            check({name, ":done_config_low"}, 32'(done_cfg), 32'd0);
            check({name, ":write_count"}, 32'(got_q.size()), 32'(N_WRITES));
            for (int i = 0; i < N_WRITES && i < got_q.size(); i++)
                check($sformatf("%s:write%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
            @(posedge clk); #1;
            start = 1'b0;
            check({name, ":idle_after_done"}, ctrl_pins(), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check({name, ":start_on_done_ignored"}, 32'({o_busy, o_config}), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        osc = '0; art = '0; rx = '0; tx = '0;
        apb.PREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", ctrl_pins(), 32'd0);
        check("reset_addr", 32'(apb.PADDR), 32'd0);
        check("reset_data", 32'(apb.PWDATA), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", ctrl_pins(), 32'd0);

        run_seq("nominal",    16'h2710, 16'h2500, 8'h03, 8'h4D, 0, 0, 0, -1);
        run_seq("wait4",      16'h2710, 16'h2500, 8'h03, 8'h4D, 4, 0, 0, -1);
        run_seq("busy_guard", 16'h2710, 16'h2500, 8'h03, 8'h4D, 0, 0, 1, -1);
        run_seq("timeout", 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 0, 1, 0, -1);
        run_seq("after_err", 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), -1, 0, 0, -1);
        run_seq("reset_mid", 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), -1, 0, 0, 15);
        run_seq("after_reset", 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), -1, 0, 0, -1);
        run_seq("e2e_values", 16'h2510, 16'h2900, 8'h01, 8'h81, 0, 0, 0, -1);
        for (int r = 0; r < 3; r++)
            run_seq($sformatf("rand%0d", r), 16'($urandom), 16'($urandom),
                    8'($urandom), 8'($urandom), -1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
